hash_lookup: RTL and testbench

- Initiator-side client of the byte-sum hash unit.
- Accepts a 64-bit key lookup request and drives the hash unit's start/key inputs, then waits for its ready/value result.
- Reads one entry of a synchronous-read key/value table at the hashed address, compares the stored key, and returns hit/miss plus data.
- Sits between the match-stage request path and the table RAM. Includes a timeout guard on the hash handshake.

---
 rtl/hash_lookup.sv | 134 +++++++++++++
 tb/tb_hash_lookup.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_lookup.sv
// hash_lookup: key/value table lookup client of the byte-sum hash unit.
// Hashes the key, reads one table slot, compares the key, returns hit/miss.
module hash_lookup #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [63:0]       req_key_i,
  output logic              hash_start_o,
  output logic [63:0]       hash_key_o,
  input  logic              hash_ready_i,
  input  logic [31:0]       hash_val_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_valid_i,
  input  logic [63:0]       mem_key_i,
  input  logic [31:0]       mem_data_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic              resp_hit_o,
  output logic              resp_err_o,
  output logic [ADDR_W-1:0] resp_addr_o,
  output logic [31:0]       resp_data_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_READ,
    S_CMP,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [63:0]       r_key;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_hit;
  logic              r_err;
  logic [ADDR_W-1:0] r_resp_addr;
  logic [31:0]       r_data;
  logic              w_hit;
  logic              w_tmo;
  logic              w_unused;

  // only the low ADDR_W hash bits form the address
  assign w_unused = ^hash_val_i;

  assign w_hit = mem_valid_i && (mem_key_i == r_key);
  assign w_tmo = (r_cnt == CNT_MAX);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (req_valid_i) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (hash_ready_i)
          w_next = S_READ;
        else if (w_tmo)
          w_next = S_RESP;
      end
      S_READ:  w_next = S_CMP;
      S_CMP:   w_next = S_RESP;
      S_RESP:  if (resp_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key       <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_hit       <= 1'b0;
      r_err       <= 1'b0;
      r_resp_addr <= '0;
      r_data      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid_i) r_key <= req_key_i;
        end
        S_START: r_cnt <= '0;
        S_WAIT: begin
          if (hash_ready_i) begin
            r_addr <= hash_val_i[ADDR_W-1:0];
          end else if (w_tmo) begin
            r_err       <= 1'b1;
            r_hit       <= 1'b0;
            r_data      <= '0;
            r_addr      <= '0;
            r_resp_addr <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CMP: begin
          r_hit       <= w_hit;
          r_data      <= w_hit ? mem_data_i : 32'h0;
          r_resp_addr <= r_addr;
          r_err       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o  = (r_state == S_IDLE);
  assign hash_start_o = (r_state == S_START);
  assign hash_key_o   = r_key;
  assign mem_rd_en_o  = (r_state == S_READ);
  assign mem_addr_o   = r_addr;
  assign resp_valid_o = (r_state == S_RESP);
  assign resp_hit_o   = r_hit;
  assign resp_err_o   = r_err;
  assign resp_addr_o  = r_resp_addr;
  assign resp_data_o  = r_data;

endmodule

// File: tb/tb_hash_lookup.sv
// tb_hash_lookup: scoreboard bench for hash_lookup with
// a 3-cycle byte-sum hash stub and a 1-cycle table RAM model.
module tb_hash_lookup;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [63:0] req_key_i = '0;
  logic        hash_start_o;
  logic [63:0] hash_key_o;
  logic        hash_ready_i;
  logic [31:0] hash_val_i;
  logic        mem_rd_en_o;
  logic [7:0]  mem_addr_o;
  logic        mem_valid_i;
  logic [63:0] mem_key_i;
  logic [31:0] mem_data_i;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic        resp_hit_o;
  logic        resp_err_o;
  logic [7:0]  resp_addr_o;
  logic [31:0] resp_data_o;

  hash_lookup #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_key_i    (req_key_i),
    .hash_start_o (hash_start_o),
    .hash_key_o   (hash_key_o),
    .hash_ready_i (hash_ready_i),
    .hash_val_i   (hash_val_i),
    .mem_rd_en_o  (mem_rd_en_o),
    .mem_addr_o   (mem_addr_o),
    .mem_valid_i  (mem_valid_i),
    .mem_key_i    (mem_key_i),
    .mem_data_i   (mem_data_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_hit_o   (resp_hit_o),
    .resp_err_o   (resp_err_o),
    .resp_addr_o  (resp_addr_o),
    .resp_data_o  (resp_data_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  // hash stub: samples start, ready visible 3 edges later
  logic       h_rdy;
  logic [31:0] h_val;
  logic [1:0] h_cnt;
  logic       h_dead = 1'b0;

  function automatic logic [31:0] bsum(input logic [63:0] k);
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < 8; i++) s = s + 32'(k[i*8 +: 8]);
    return s;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_rdy <= 1'b0;
      h_val <= '0;
      h_cnt <= '0;
    end else if (hash_start_o) begin
      h_rdy <= 1'b0;
      h_cnt <= 2'd1;
      h_val <= bsum(hash_key_o);
    end else if (h_cnt == 2'd2) begin
      h_cnt <= 2'd0;
      h_rdy <= !h_dead;
    end else if (h_cnt != 2'd0) begin
      h_cnt <= h_cnt + 2'd1;
    end
  end

  assign hash_ready_i = h_rdy;
  assign hash_val_i   = h_val;

  // table RAM model
  logic        tv [256];
  logic [63:0] tk [256];
  logic [31:0] td [256];
  logic        mv;
  logic [63:0] mk;
  logic [31:0] md;

  always @(posedge clk) begin
    if (mem_rd_en_o) begin
      mv <= tv[mem_addr_o];
      mk <= tk[mem_addr_o];
      md <= td[mem_addr_o];
    end
  end

  assign mem_valid_i = mv;
  assign mem_key_i   = mk;
  assign mem_data_i  = md;

  typedef struct {
    logic        hit;
    logic        err;
    logic [7:0]  addr;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   mon_prev = 0;

  task automatic push(input logic hit, input logic err,
                      input logic [7:0] addr,
                      input logic [31:0] data,
                      input int lat);
    exp_t e;
    e.hit = hit; e.err = err; e.addr = addr;
    e.data = data; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // monitor: first valid cycle pops and compares, later ones check hold
  always @(negedge clk) begin
    if (!rst) begin
      mon_prev = 0;
    end else if (resp_valid_o) begin
      if (!mon_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 64'(exp_q.size()), 64'd1);
        end else begin
          cur = exp_q.pop_front();
          chk("latency", 64'(cyc - last_acc), 64'(cur.lat));
          chk("hit", 64'(resp_hit_o), 64'(cur.hit));
          chk("err", 64'(resp_err_o), 64'(cur.err));
          chk("addr", 64'(resp_addr_o), 64'(cur.addr));
          chk("data", 64'(resp_data_o), 64'(cur.data));
        end
      end else begin
        chk("hold_hit", 64'(resp_hit_o), 64'(cur.hit));
        chk("hold_err", 64'(resp_err_o), 64'(cur.err));
        chk("hold_addr", 64'(resp_addr_o), 64'(cur.addr));
        chk("hold_data", 64'(resp_data_o), 64'(cur.data));
      end
      chk("req_ready_busy", 64'(req_ready_o), 64'd0);
      mon_prev = 1;
    end else begin
      mon_prev = 0;
    end
  end

  task automatic send(input logic [63:0] k, output int acc);
    int n;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_key_i   = k;
    n = 0;
    while (!req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o)
      chk("accept_timeout", 64'(req_ready_o), 64'd1);
    acc = cyc + 1;
    last_acc = acc;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!resp_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid_o)
      chk("valid_timeout", 64'(resp_valid_o), 64'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(resp_valid_o && resp_ready_i) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!(resp_valid_o && resp_ready_i))
      chk("done_timeout", 64'(resp_valid_o), 64'd1);
    @(negedge clk);
  endtask

  localparam logic [63:0] K1 = 64'h0102030405060708;
  localparam logic [63:0] K2 = 64'h0807060504030201;
  localparam logic [63:0] K3 = 64'h0000000000000010;
  localparam logic [63:0] K4 = 64'hFFFFFFFFFFFFFFFF;

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;
    for (int i = 0; i < 256; i++) begin
      tv[i] = 1'b0; tk[i] = '0; td[i] = '0;
    end
    tv[8'h24] = 1'b1; tk[8'h24] = K1; td[8'h24] = 32'hDEADBEEF;
    tv[8'h10] = 1'b0; tk[8'h10] = K3; td[8'h10] = 32'h12345678;
    tv[8'hF8] = 1'b1; tk[8'hF8] = K4; td[8'hF8] = 32'hCAFEF00D;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_hash_start", 64'(hash_start_o), 64'd0);
    chk("rst_mem_rd_en", 64'(mem_rd_en_o), 64'd0);
    chk("rst_hash_key", hash_key_o, 64'd0);
    chk("rst_resp_bus", 64'({resp_hit_o, resp_err_o,
        resp_addr_o, resp_data_o}), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    push(1, 0, 8'h24, 32'hDEADBEEF, 6);
    send(K1, a1);
    chk("hash_key_held", hash_key_o, K1);
    wait_done();

    push(0, 0, 8'h24, 32'h0, 6);
    send(K2, a1);
    wait_done();

    push(0, 0, 8'h10, 32'h0, 6);
    send(K3, a1);
    wait_done();

    push(1, 0, 8'hF8, 32'hCAFEF00D, 6);
    send(K4, a1);
    wait_done();

    resp_ready_i = 1'b0;
    push(1, 0, 8'h24, 32'hDEADBEEF, 6);
    send(K1, a1);
    wait_valid();
    repeat (5) @(negedge clk);
    resp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_req_ready_after", 64'(req_ready_o), 64'd1);
    chk("bp_valid_after", 64'(resp_valid_o), 64'd0);
    chk("bp_data_kept", 64'(resp_data_o), 64'hDEADBEEF);

    push(1, 0, 8'h24, 32'hDEADBEEF, 6);
    push(0, 0, 8'h10, 32'h0, 6);
    send(K1, a1);
    send(K3, a2);
    chk("b2b_spacing", 64'(a2 - a1), 64'd8);
    wait_done();

    h_dead = 1'b1;
    push(0, 1, 8'h00, 32'h0, 17);
    send(K1, a1);
    wait_done();
    h_dead = 1'b0;
    push(1, 0, 8'h24, 32'hDEADBEEF, 6);
    send(K1, a1);
    wait_done();

    send(K1, a1);
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rstw_valid", 64'(resp_valid_o), 64'd0);
    chk("rstw_req_ready", 64'(req_ready_o), 64'd1);
    chk("rstw_hash_start", 64'(hash_start_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("rstw_no_resp", 64'(resp_valid_o), 64'd0);

    resp_ready_i = 1'b0;
    push(1, 0, 8'h24, 32'hDEADBEEF, 6);
    send(K1, a1);
    wait_valid();
    #3 rst = 1'b0;
    #1;
    chk("rstr_valid", 64'(resp_valid_o), 64'd0);
    chk("rstr_req_ready", 64'(req_ready_o), 64'd1);
    chk("rstr_resp_data", 64'(resp_data_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    resp_ready_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("rstr_no_resp", 64'(resp_valid_o), 64'd0);

    push(1, 0, 8'h24, 32'hDEADBEEF, 6);
    send(K1, a1);
    wait_done();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
